cam_frame_status: RTL and testbench

- Upstream neighbour of the camera PIO input port.
- Watches the camera timing strobes (vsync, href, pix_valid) in the clk domain and measures each frame: line count, pixels per line, frame sequence number.
- Packs the results into a 32-bit registered status word that drives the PIO in_port directly.
- The PIO edge-captures falling edges, so event bits are encoded as falling edges: busy falls at frame end; ok falls on a geometry error.

---
 rtl/cam_frame_status_pkg.sv | 42 ++++
 rtl/cam_frame_status_if.sv | 11 +
 rtl/cam_edge_det.sv | 22 ++
 rtl/cam_frame_status.sv | 147 ++++++++++++++
 tb/tb_cam_frame_status.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/cam_frame_status_pkg.sv
// Shared definitions for the camera frame status block: FSM states and the
// bit layout of the status word that software decodes from the PIO.
package cam_frame_status_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    VSYNC   = 2'd2,
    ACTIVE  = 2'd3
  } state_t;

  localparam int BUSY_BIT  = 0;
  localparam int OK_BIT    = 1;
  localparam int STATE_LSB = 2;
  localparam int LINES_LSB = 4;
  localparam int LEN_LSB   = 16;
  localparam int FCNT_LSB  = 28;

  localparam int STATE_W = 2;
  localparam int FIELD_W = 12;
  localparam int FCNT_W  = 4;

  function automatic logic [31:0] pack_status(
    input logic               busy,
    input logic               ok,
    input state_t             st,
    input logic [FIELD_W-1:0] lines,
    input logic [FIELD_W-1:0] len,
    input logic [FCNT_W-1:0]  fcnt
  );
    logic [31:0] w;
    w                         = '0;
    w[BUSY_BIT]               = busy;
    w[OK_BIT]                 = ok;
    w[STATE_LSB +: STATE_W]   = st;
    w[LINES_LSB +: FIELD_W]   = lines;
    w[LEN_LSB +: FIELD_W]     = len;
    w[FCNT_LSB +: FCNT_W]     = fcnt;
    return w;
  endfunction

endpackage

// File: rtl/cam_frame_status_if.sv
// Camera timing strobes as seen by the frame status block.
interface cam_frame_status_if;

  logic vsync;
  logic href;
  logic pix_valid;

  modport master (output vsync, href, pix_valid);
  modport slave  (input  vsync, href, pix_valid);

endinterface

// File: rtl/cam_edge_det.sv
// Rise/fall detector: compares each input bit against its one-cycle-old copy.
module cam_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sig,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] sig_d;

  always_ff @(posedge clk) begin
    if (reset) sig_d <= '0;
    else       sig_d <= sig;
  end

  assign rise = sig & ~sig_d;
  assign fall = ~sig & sig_d;

endmodule

// File: rtl/cam_frame_status.sv
// Measures camera frame geometry and packs it into a registered status word
// whose busy/ok bits signal events to an edge-capturing PIO as falling edges.
module cam_frame_status
  import cam_frame_status_pkg::*;
#(
  parameter int EXP_LINES  = 480,
  parameter int EXP_PIXELS = 640,
  parameter int CNT_W      = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  cam_frame_status_if.slave        cam,
  output logic [31:0]              status_word,
  output logic                     frame_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_L   = CNT_W'(EXP_LINES);
  localparam logic [CNT_W-1:0] EXP_P   = CNT_W'(EXP_PIXELS);

  logic vs_rise, vs_fall, hr_rise, hr_fall;
  logic pix_beat;

  state_t               state, state_nxt;
  logic                 busy, busy_nxt;
  logic                 ok, ok_nxt;
  logic [CNT_W-1:0]     line_cnt, line_cnt_nxt;
  logic [CNT_W-1:0]     pix_cnt, pix_cnt_nxt;
  logic [CNT_W-1:0]     last_len, last_len_nxt;
  logic [FIELD_W-1:0]   lines_fld, lines_fld_nxt;
  logic [FIELD_W-1:0]   len_fld, len_fld_nxt;
  logic [FCNT_W-1:0]    frame_cnt, frame_cnt_nxt;
  logic                 frame_done_nxt;

  cam_edge_det #(.W(1)) u_vs_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (cam.vsync),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );

  cam_edge_det #(.W(1)) u_hr_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (cam.href),
    .rise  (hr_rise),
    .fall  (hr_fall)
  );

  assign pix_beat = cam.pix_valid & cam.href;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      ok          <= 1'b1;
      line_cnt    <= '0;
      pix_cnt     <= '0;
      last_len    <= '0;
      lines_fld   <= '0;
      len_fld     <= '0;
      frame_cnt   <= '0;
      frame_done  <= 1'b0;
      status_word <= pack_status(1'b0, 1'b1, IDLE, '0, '0, '0);
    end else begin
      state       <= state_nxt;
      busy        <= busy_nxt;
      ok          <= ok_nxt;
      line_cnt    <= line_cnt_nxt;
      pix_cnt     <= pix_cnt_nxt;
      last_len    <= last_len_nxt;
      lines_fld   <= lines_fld_nxt;
      len_fld     <= len_fld_nxt;
      frame_cnt   <= frame_cnt_nxt;
      frame_done  <= frame_done_nxt;
      status_word <= pack_status(busy_nxt, ok_nxt, state_nxt, lines_fld_nxt,
                                 len_fld_nxt, frame_cnt_nxt);
    end
  end

  // Counters saturate so an overlong frame or line always reads as a mismatch.
  always_comb begin
    state_nxt      = state;
    busy_nxt       = busy;
    ok_nxt         = ok;
    line_cnt_nxt   = line_cnt;
    pix_cnt_nxt    = pix_cnt;
    last_len_nxt   = last_len;
    lines_fld_nxt  = lines_fld;
    len_fld_nxt    = len_fld;
    frame_cnt_nxt  = frame_cnt;
    frame_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (arm) begin
          state_nxt = WAIT_VS;
          ok_nxt    = 1'b1;
        end
      end

      WAIT_VS: begin
        if (!arm)         state_nxt = IDLE;
        else if (vs_rise) state_nxt = VSYNC;
      end

      VSYNC: begin
        if (vs_fall) begin
          state_nxt    = ACTIVE;
          busy_nxt     = 1'b1;
          line_cnt_nxt = '0;
          pix_cnt_nxt  = '0;
          last_len_nxt = '0;
        end
      end

      ACTIVE: begin
        if (pix_beat && pix_cnt != CNT_MAX) pix_cnt_nxt = pix_cnt + CNT_W'(1);

        // A new vsync commits the frame and masks any href edge on that cycle.
        if (vs_rise) begin
          busy_nxt       = 1'b0;
          frame_done_nxt = 1'b1;
          frame_cnt_nxt  = frame_cnt + FCNT_W'(1);
          lines_fld_nxt  = FIELD_W'(line_cnt);
          len_fld_nxt    = FIELD_W'(last_len);
          if (line_cnt != EXP_L) ok_nxt = 1'b0;
          state_nxt      = arm ? VSYNC : IDLE;
        end else begin
          if (hr_rise) begin
            if (line_cnt != CNT_MAX) line_cnt_nxt = line_cnt + CNT_W'(1);
            pix_cnt_nxt = pix_beat ? CNT_W'(1) : '0;
          end
          if (hr_fall) begin
            last_len_nxt = pix_cnt_nxt;
            if (pix_cnt_nxt != EXP_P) ok_nxt = 1'b0;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cam_frame_status.sv
// Directed bench for cam_frame_status: a table of whole-frame vectors plus
// hand-built sequences for coincident edges, reset mid-frame and counter wrap.
module tb_cam_frame_status;

  localparam int EXP_LINES  = 4;
  localparam int EXP_PIXELS = 8;
  localparam int CNT_W      = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic [31:0] status_word;
  logic        frame_done;

  cam_frame_status_if camIf();

  cam_frame_status #(
    .EXP_LINES  (EXP_LINES),
    .EXP_PIXELS (EXP_PIXELS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .cam         (camIf),
    .status_word (status_word),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lines;
    int          beats;
    int          oddLine;
    int          oddBeats;
    int          armDropLine;
    logic [31:0] expStatus;
    string       name;
  } frame_vec_t;

  frame_vec_t tbl[6];
  frame_vec_t wrapVec;
  int vecCount  = 0;
  int missCount = 0;

  // Drive one cycle of strobes, then sample just after the active edge.
  task automatic applyStimulus(input logic v, input logic h, input logic p);
    camIf.vsync     = v;
    camIf.href      = h;
    camIf.pix_valid = p;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic sendLine(input int n);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int b = 0; b < n; b++) applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic runFrame(input frame_vec_t f);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput({f.name, "_busy_rise"}, {31'b0, status_word[0]}, 32'd1);
    for (int l = 0; l < f.lines; l++) begin
      if (l == f.armDropLine) arm = 1'b0;
      sendLine((l == f.oddLine) ? f.oddBeats : f.beats);
      if (l == f.oddLine)
        checkOutput({f.name, "_ok_fall"}, {31'b0, status_word[1]}, 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput({f.name, "_status"}, status_word, f.expStatus);
    checkOutput({f.name, "_done"}, {31'b0, frame_done}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput({f.name, "_done_end"}, {31'b0, frame_done}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{4, 8, -1,  0, -1, 32'h1008_004A, "good_frame"};
    tbl[1] = '{4, 8,  2,  7, -1, 32'h2008_0048, "short_line"};
    tbl[2] = '{4, 8, -1,  0, -1, 32'h3008_0048, "ok_sticky"};
    tbl[3] = '{4, 8, -1,  0,  2, 32'h4008_0040, "arm_drop"};
    tbl[4] = '{5, 8, -1,  0, -1, 32'h5008_0058, "five_lines"};
    tbl[5] = '{4, 8,  3, 20, -1, 32'h600F_0048, "pix_saturate"};

    arm   = 1'b0;
    reset = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reset_status", status_word, 32'h0000_0002);
    checkOutput("reset_done", {31'b0, frame_done}, 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_unarmed", status_word, 32'h0000_0002);
    arm = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("armed_wait_vs", status_word, 32'h0000_0006);

    for (int i = 0; i < 6; i++) begin
      runFrame(tbl[i]);
      if (i == 3) begin
        // Back in IDLE with arm low: vsync activity must not touch anything.
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle_vsync_ignored", status_word, 32'h4008_0040);
        checkOutput("idle_no_done", {31'b0, frame_done}, 32'd0);
        arm = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rearm_ok_restore", status_word, 32'h4008_0046);
      end
    end

    // Stray pixels outside href, and href falling on the committing vsync.
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("coinc_fall_active", status_word, 32'h600F_004D);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    for (int l = 0; l < 3; l++) sendLine(8);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (7) applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("coinc_fall_status", status_word, 32'h7008_0048);
    checkOutput("coinc_fall_done", {31'b0, frame_done}, 32'd1);

    // href rising on the committing vsync must not add a line.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 4; l++) sendLine(8);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("coinc_rise_status", status_word, 32'h8008_0048);
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Reset in the middle of a frame discards it.
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("midframe_reset_status", status_word, 32'h0000_0002);
    checkOutput("midframe_reset_done", {31'b0, frame_done}, 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_armed", status_word, 32'h0000_0006);

    for (int k = 1; k <= 17; k++) begin
      wrapVec = '{4, 8, -1, 0, -1, {4'(k), 12'd8, 12'd4, 4'hA}, "wrap_frame"};
      runFrame(wrapVec);
    end
    checkOutput("fcnt_wrapped", {28'b0, status_word[31:28]}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
